// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
// Contents: baud divider table, parity mode encodings, receiver FSM state
// enum, sampling constants and a 2-of-3 majority helper.
package uart_pkg;

    localparam int unsigned SAMPLES_PER_BIT = 16;
    localparam int unsigned SAMPLE_CNT_W    = $clog2(SAMPLES_PER_BIT);

    // Samples that vote on each bit; the decision is taken on the last one.
    localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_VOTE_A = 4'd7;
    localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_VOTE_B = 4'd8;
    localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_VOTE_C = 4'd9;

    // clk cycles per 16x sample tick, indexed by baud_select.
    // 0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud at 50 MHz.
    localparam int unsigned BAUD_DIV_W = 14;
    localparam logic [BAUD_DIV_W-1:0] BAUD_DIV [8] = '{
        14'd10417, 14'd2604, 14'd651, 14'd326, 14'd163, 14'd81, 14'd54, 14'd27
    };

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_controller.sv
// 16x oversampling tick generator.
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   baud_select    rate index into BAUD_DIV
//   sample_enable  one-cycle pulse per sample tick
module uart_baud_controller
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_enable
);

    logic [BAUD_DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]            sel_q;
    logic                  tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (baud_select != sel_q) begin
            // Restart the divider so a new rate takes effect from a clean phase.
            cnt_d = '0;
        end else if (cnt_q >= BAUD_DIV[baud_select] - 14'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= baud_select;
            tick_q <= tick_d;
        end
    end

    assign sample_enable = tick_q;

endmodule

// File: rtl/uart_receiver_param.sv
// Parameterised UART receiver with 3-of-16 majority sampling and a
// valid/ready output buffer.
// Optional feature macro: UART_RX_FIFO_EN selects a FIFO_DEPTH-entry circular
// FIFO; when undefined a single holding register is used.
// Ports:
//   clk, reset   50 MHz clock, asynchronous active-high reset
//   baud_select  rate index (see uart_pkg::BAUD_DIV)
//   RX_EN        receiver enable; low aborts any partial frame
//   RxD          synchronised serial input, idles high
//   Rx_READY     consumer accepts the head entry
//   Rx_DATA      head-entry payload (0 when empty)
//   Rx_VALID     head entry present
//   Rx_PERROR    head-entry parity error
//   Rx_FERROR    head-entry framing error
//   Rx_OVERRUN   one-cycle pulse when a frame is dropped on a full buffer
module uart_receiver_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           baud_select,
    input  logic                 RX_EN,
    input  logic                 RxD,
    input  logic                 Rx_READY,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_OVERRUN
);

    localparam int unsigned ENTRY_W = DATA_BITS + 2;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_param_check
        $error("uart_receiver_param: illegal parameter set");
    end

    logic sample_enable;

    uart_baud_controller u_baud (
        .clk          (clk),
        .reset        (reset),
        .baud_select  (baud_select),
        .sample_enable(sample_enable)
    );

    rx_state_e                state_q, state_d;
    logic [SAMPLE_CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic [1:0]               vote_q, vote_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     stop_cnt_q, stop_cnt_d;
    logic                     commit_q, commit_d;
    logic                     maj;

    // Samples 7 and 8 are held in vote_q; sample 9 is the live RxD.
    assign maj = majority3(vote_q[0], vote_q[1], RxD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        vote_d     = vote_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_cnt_d = stop_cnt_q;
        commit_d   = 1'b0;
        if (!RX_EN) begin
            state_d = StIdle;
        end else if (sample_enable) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SAMPLE_VOTE_A) vote_d[0] = RxD;
            if (cnt_q == SAMPLE_VOTE_B) vote_d[1] = RxD;
            unique case (state_q)
                StIdle: begin
                    if (!RxD) begin
                        // This tick is sample 0 of the start bit.
                        state_d    = StStart;
                        cnt_d      = 4'd1;
                        bit_cnt_d  = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        stop_cnt_d = 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_q == SAMPLE_VOTE_C) state_d = maj ? StIdle : StData;
                end
                StData: begin
                    if (cnt_q == SAMPLE_VOTE_C) begin
                        shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            state_d = (PARITY_MODE == PARITY_NONE) ? StStop : StParity;
                        end
                    end
                end
                StParity: begin
                    if (cnt_q == SAMPLE_VOTE_C) begin
                        perr_d  = maj != ((^shift_q) ^ (PARITY_MODE == PARITY_ODD));
                        state_d = StStop;
                    end
                end
                StStop: begin
                    if (cnt_q == SAMPLE_VOTE_C) begin
                        if (!maj) ferr_d = 1'b1;
                        if (STOP_BITS == 2 && !stop_cnt_q) begin
                            stop_cnt_d = 1'b1;
                        end else begin
                            commit_d = 1'b1;
                            // After a framing error, demand a clean idle bit so a break
                            // line does not immediately look like a new start bit.
                            state_d  = (ferr_q || !maj) ? StWaitIdle : StIdle;
                            cnt_d    = '0;
                        end
                    end
                end
                StWaitIdle: begin
                    // cnt counts consecutive high samples here.
                    if (!RxD) cnt_d = '0;
                    else if (cnt_q == SAMPLE_CNT_W'(SAMPLES_PER_BIT - 1)) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            vote_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            vote_q     <= vote_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop_cnt_q <= stop_cnt_d;
            commit_q   <= commit_d;
        end
    end

    // Output buffer
    logic [ENTRY_W-1:0] wr_entry, head;
    logic               empty, full, pop, push, overrun_q;

    assign wr_entry = {shift_q, perr_q, ferr_q};
    assign pop      = Rx_VALID & Rx_READY;
    // A pop in the commit cycle frees the slot the commit needs.
    assign push     = commit_q & (~full | pop);

`ifdef UART_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
`else
    logic               hold_valid_q;
    logic [ENTRY_W-1:0] hold_q;

    assign empty = ~hold_valid_q;
    assign full  = hold_valid_q;
    assign head  = hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else if (push) begin
            hold_valid_q <= 1'b1;
            hold_q       <= wr_entry;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= commit_q & full & ~pop;
    end

    assign Rx_VALID   = ~empty;
    assign Rx_DATA    = Rx_VALID ? head[ENTRY_W-1:2] : '0;
    assign Rx_PERROR  = Rx_VALID & head[1];
    assign Rx_FERROR  = Rx_VALID & head[0];
    assign Rx_OVERRUN = overrun_q;

endmodule

// File: doc/uart_receiver_param.md
Name: uart_receiver_param

Overview:
- Next-generation UART receiver for the serial-link datapath.
- Adds generic frame format (data bits, parity mode, stop bits) and 3-of-16 majority-vote bit sampling to reject mid-bit noise.
- Buffers received frames with a valid/ready handshake instead of a bare one-shot Rx_VALID pulse, and adds overrun reporting.
- Sits between the RxD pad synchroniser and the display/consumer logic, on the same 50 MHz clock.

Parameters:
- DATA_BITS, 8: payload bits per frame, legal 5..9, LSB first.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries when UART_RX_FIFO_EN is defined; power of two, 2..16.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- baud_select  in  3  0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
- RX_EN  in  1  receiver enable.
- RxD  in  1  serial input, already synchronised; idles high.
- Rx_READY  in  1  consumer accepts the head entry.
- Rx_DATA  out  DATA_BITS  head-entry payload.
- Rx_VALID  out  1  head entry present.
- Rx_PERROR  out  1  parity error flag of the head entry.
- Rx_FERROR  out  1  framing error flag of the head entry.
- Rx_OVERRUN  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, buffer empty. Reset asserted mid-frame discards the frame and the buffer immediately.
- Sample tick is 16x baud. Divider values: 10417, 2604, 651, 326, 163, 81, 54, 27 clk cycles.
  - The divider counter restarts on any baud_select change.
  - A baud_select change mid-frame corrupts that frame but must never hang the FSM.
- Each bit is resolved by majority vote of samples 7, 8 and 9 of its 16-sample window.
- FSM states and transitions:
  - IDLE: a sample of RxD = 0 while RX_EN = 1 moves to START and clears the sample counter.
  - START: at sample 9, a majority of 0 moves to DATA; a majority of 1 is a glitch and returns to IDLE with nothing written.
  - DATA: DATA_BITS bits, shifted LSB first. Then PARITY, or STOP when PARITY_MODE = 0.
  - PARITY: compares the received bit with the XOR of the data, inverted for odd parity. A mismatch sets the parity flag.
  - STOP: a majority of 0 sets the framing flag. When STOP_BITS = 2, both stop bits are checked and either 0 sets the flag.
  - The frame is then committed and the FSM moves to IDLE. After a framing error it moves to WAIT_IDLE instead.
  - WAIT_IDLE: waits for one full bit time of RxD = 1 before re-arming, so a break does not retrigger.
- Commit:
  - The frame is written as {data, perror, ferror} in the clk cycle after the final stop-bit decision.
  - Frames with errors are stored, not dropped.
- Handshake:
  - An entry pops when Rx_VALID & Rx_READY at a clk edge.
  - Outputs show the next entry the following cycle, or Rx_VALID = 0 if the buffer is empty.
  - Rx_DATA and the flags are stable while Rx_VALID = 1 and not popped.
- Full buffer at commit: the frame is dropped and Rx_OVERRUN pulses for 1 cycle. If a pop happens in the same cycle as the commit, the commit succeeds.
- Simultaneous push and pop on an empty buffer: the push wins and Rx_VALID rises next cycle.
- RX_EN low: the FSM returns to IDLE on the next clk edge and any partial frame is discarded. Buffered entries are retained and still drainable.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined: circular FIFO of FIFO_DEPTH entries with wrap-around read/write pointers and an extra occupancy bit.
- Undefined: a single holding register (depth 1), with the same handshake and overrun rules.

Decomposition:
- Shared package uart_pkg:
  - baud divider constants array;
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD encodings;
  - receiver FSM state enum;
  - SAMPLES_PER_BIT = 16 and majority sample indices 7/8/9.
- Sub-module uart_baud_controller: baud_select in, one-cycle sample_enable out. The existing uart_baud_controller is reused unchanged if it matches this interface.
- FIFO stays inline.

Test Plan:
- 8E1 at 115200, frame 0xA1, even parity bit 1, stop 1, Rx_READY = 1 -> Rx_DATA = 8'hA1, Rx_VALID high for 1 cycle, PERROR = 0, FERROR = 0.
- Same frame with D0 held low for 7 of its 16 samples, avoiding samples 7–9 -> still 8'hA1 with no errors.
- 0xA1 with parity bit 0 -> PERROR = 1. Stop bit 0 -> FERROR = 1; a following good frame 0x3C is received correctly after RxD idles for one bit time.
- RxD low for 3 sample ticks only -> no commit, Rx_VALID stays 0.
- FIFO_EN, depth 4, Rx_READY = 0, five frames 0x01..0x05 -> Rx_OVERRUN pulses once on frame 5. Raising Rx_READY drains 0x01..0x04 in order.
- RX_EN dropped mid-DATA of 0x55, then re-enabled, then 0x66 sent -> only 8'h66 delivered. Reset mid-frame -> all outputs 0 and buffer empty.
